// File: rtl/cla_multiword_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_multiword_seq_if : operand / result valid-ready bundle for cla_multiword_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cla_multiword_seq_if #(
  parameter int WORDS = 4
) ();
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, sign, out_ready,
    input  in_ready, out_valid, result, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub, sign, out_ready,
    output in_ready, out_valid, result, cout, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/cla_multiword_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_multiword_seq : WORDS x 16-bit add/sub sequenced through one 16-bit CLA,
// LS slice first. Optional CLA_SEQ_SAT_EN saturates the DONE result on overflow.
// Revision: 1.0
// ---------------------------------------------------------------------------

module CLA_16bit_h (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        cin,
  input  wire logic        control,
  output logic      [15:0] sum,
  output logic             cout
);
  logic [15:0] w_b;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic        w_cin;

  // control=1 turns the adder into a subtractor (invert b, force carry-in)
  assign w_b   = b ^ {16{control}};
  assign w_cin = cin | control;
  assign w_g   = a & w_b;
  assign w_p   = a ^ w_b;

  // second-level lookahead across the four 4-bit groups
  assign w_gc[0] = w_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & w_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & w_cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_cin);
  assign cout    = w_gc[4];

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] w_gl;
    logic [3:0] w_pl;
    logic [3:0] w_cl;

    assign w_gl = w_g[4*k +: 4];
    assign w_pl = w_p[4*k +: 4];

    assign w_cl[0] = w_gc[k];
    assign w_cl[1] = w_gl[0] | (w_pl[0] & w_gc[k]);
    assign w_cl[2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_gc[k]);
    assign w_cl[3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                   | (w_pl[2] & w_pl[1] & w_pl[0] & w_gc[k]);

    assign w_gg[k] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                   | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
    assign w_gp[k] = &w_pl;

    assign sum[4*k +: 4] = w_pl ^ w_cl;
  end
endmodule

module cla_multiword_seq #(
  parameter int WORDS = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cla_multiword_seq_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] c_last = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sub;
  logic          r_sign;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_overflow;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic [15:0]   w_a_slice;
  logic [15:0]   w_b_slice;
  logic [15:0]   w_sum;
  logic          w_cout;
  logic          w_ovf;

  assign w_a_slice = r_a[16*r_idx +: 16];
  assign w_b_slice = r_b[16*r_idx +: 16];

  // r_b already holds ~b for subtraction, so the CLA always adds
  CLA_16bit_h u_cla (
    .a       (w_a_slice),
    .b       (w_b_slice),
    .cin     (r_carry),
    .control (1'b0),
    .sum     (w_sum),
    .cout    (w_cout)
  );

  // only meaningful while the top slice is on the CLA
  always_comb begin
    w_ovf = 1'b0;
    if (r_sign)
      w_ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[15] != r_a[W-1]);
    else if (r_sub)
      w_ovf = ~w_cout;
    else
      w_ovf = w_cout;
  end

`ifdef CLA_SEQ_SAT_EN
  logic [W-1:0] w_sat;

  always_comb begin
    w_sat = '0;
    if (r_sign)
      w_sat = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else if (!r_sub)
      w_sat = '1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_sign      <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_sub      <= bus.sub;
            r_sign     <= bus.sign;
            r_carry    <= bus.sub;
            r_idx      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[16*r_idx +: 16] <= w_sum;
          r_carry                  <= w_cout;
          if (r_idx == c_last) begin
            r_cout      <= w_cout;
            r_overflow  <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef CLA_SEQ_SAT_EN
            if (w_ovf)
              r_result <= w_sat;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_cla_multiword_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cla_multiword_seq : directed vectors for cla_multiword_seq (WORDS=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cla_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cla_multiword_seq_if #(.WORDS(WORDS)) bus ();

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present operands for one accept edge, then scramble them; returns edges
  // after the accept edge until out_valid is seen (bounded)
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tg, output int lat);
    bus.a = ta; bus.b = tb; bus.sub = ts; bus.sign = tg; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~ta; bus.b = ~tb; bus.sub = ~ts; bus.sign = ~tg;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.sign = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 10000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow});
    end
    vectors++;
    if (bus.result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h expected 0", bus.result);
    end
  endtask

  task automatic test_unsigned_add();
    int lat;
    bus.a = 64'h0000_0000_0000_FFFF; bus.b = 64'h1;
    bus.sub = 1'b0; bus.sign = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL accept_state: got %b expected 100", {bus.busy, bus.in_ready, bus.out_valid});
    end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    // counting the accept edge itself, out_valid rises on edge WORDS+1
    vectors++;
    if (lat !== WORDS + 1) begin
      miscompares++;
      $display("FAIL add_latency: got %0d edges expected %0d", lat, WORDS + 1);
    end
    vectors++;
    if ({bus.cout, bus.overflow, bus.result} !== {1'b0, 1'b0, 64'h0000_0000_0001_0000}) begin
      miscompares++;
      $display("FAIL uadd_carry_chain: got c=%b o=%b r=%h expected c=0 o=0 r=0000000000010000",
               bus.cout, bus.overflow, bus.result);
    end
    release_op();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL release_idle: got %b expected 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_arith();
    int lat;
    logic [W-1:0] exp_r;

    run_op(64'h5, 64'h7, 1'b1, 1'b0, lat);
`ifdef CLA_SEQ_SAT_EN
    exp_r = 64'h0;
`else
    exp_r = 64'hFFFF_FFFF_FFFF_FFFE;
`endif
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b0, 1'b1, exp_r}) begin
      miscompares++;
      $display("FAIL usub_borrow: got lat=%0d c=%b o=%b r=%h expected lat=%0d c=0 o=1 r=%h",
               lat, bus.cout, bus.overflow, bus.result, WORDS, exp_r);
    end
    release_op();

    run_op(64'h7, 64'h5, 1'b1, 1'b0, lat);
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b1, 1'b0, 64'h2}) begin
      miscompares++;
      $display("FAIL usub_noborrow: got lat=%0d c=%b o=%b r=%h expected c=1 o=0 r=2",
               lat, bus.cout, bus.overflow, bus.result);
    end
    release_op();

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
`ifdef CLA_SEQ_SAT_EN
    exp_r = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_r = 64'h0;
`endif
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b1, 1'b1, exp_r}) begin
      miscompares++;
      $display("FAIL uadd_wrap: got lat=%0d c=%b o=%b r=%h expected c=1 o=1 r=%h",
               lat, bus.cout, bus.overflow, bus.result, exp_r);
    end
    release_op();

    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, lat);
`ifdef CLA_SEQ_SAT_EN
    exp_r = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_r = 64'h8000_0000_0000_0000;
`endif
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b0, 1'b1, exp_r}) begin
      miscompares++;
      $display("FAIL sadd_pos_ovf: got lat=%0d c=%b o=%b r=%h expected c=0 o=1 r=%h",
               lat, bus.cout, bus.overflow, bus.result, exp_r);
    end
    release_op();

    run_op(64'h6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, lat);
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b0, 1'b0, 64'h9}) begin
      miscompares++;
      $display("FAIL ssub_neg: got lat=%0d c=%b o=%b r=%h expected c=0 o=0 r=9",
               lat, bus.cout, bus.overflow, bus.result);
    end
    release_op();

    // most negative minus one overflows towards negative
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, lat);
`ifdef CLA_SEQ_SAT_EN
    exp_r = 64'h8000_0000_0000_0000;
`else
    exp_r = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b1, 1'b1, exp_r}) begin
      miscompares++;
      $display("FAIL ssub_neg_ovf: got lat=%0d c=%b o=%b r=%h expected c=1 o=1 r=%h",
               lat, bus.cout, bus.overflow, bus.result, exp_r);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = i[1];
      bus.sign = i[2];
      tick();
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.cout, bus.overflow, bus.result} !==
          {5'b10100, 64'h2345_6789_ABCD_F001}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got v=%b rdy=%b busy=%b c=%b o=%b r=%h expected 1 0 1 0 0 2345_6789_abcd_f001",
                 i, bus.out_valid, bus.in_ready, bus.busy, bus.cout, bus.overflow, bus.result);
      end
    end
    bus.in_valid = 1'b0;
    release_op();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL hold_release: got %b expected 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1;
    bus.sub = 1'b0; bus.sign = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow, bus.result} !==
        {5'b10000, 64'h0}) begin
      miscompares++;
      $display("FAIL midrun_reset: got rdy=%b v=%b busy=%b c=%b o=%b r=%h expected 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow, bus.result);
    end
    run_op(64'h3, 64'h4, 1'b0, 1'b0, lat);
    vectors++;
    if ({lat, bus.cout, bus.overflow, bus.result} !== {WORDS, 1'b0, 1'b0, 64'h7}) begin
      miscompares++;
      $display("FAIL after_reset_op: got lat=%0d c=%b o=%b r=%h expected c=0 o=0 r=7",
               lat, bus.cout, bus.overflow, bus.result);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    int   rise0;
    int   rise1;
    int   n;
    logic prev;
    logic [W-1:0] first_r;
    rise0 = -1; rise1 = -1; prev = 1'b0; first_r = '0; n = 0;
    bus.a = 64'h1; bus.b = 64'h2; bus.sub = 1'b0; bus.sign = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    while (rise1 < 0 && n < 40) begin
      tick();
      n++;
      if (bus.out_valid === 1'b1 && prev !== 1'b1) begin
        if (rise0 < 0) begin
          rise0 = n;
          first_r = bus.result;
        end else begin
          rise1 = n;
        end
      end
      prev = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (rise1 - rise0 !== WORDS + 2 || rise0 < 0) begin
      miscompares++;
      $display("FAIL b2b_period: got %0d cycles expected %0d", rise1 - rise0, WORDS + 2);
    end
    vectors++;
    if (first_r !== 64'h3) begin
      miscompares++;
      $display("FAIL b2b_result: got %h expected 3", first_r);
    end
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_idle: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_unsigned_add();
    test_arith();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
